pixel_sequencer: RTL
====================

# pixel_sequencer

Parametrised frame sequencer for the pixel sensor array. It drives each frame through erase, expose, convert and row-by-row readout. Compared with the fixed-timing sensor state block it adds:
- a runtime-programmable exposure time;
- start, busy and abort control;
- continuous (free-running) capture;
- a frame counter.

It sits between the top-level controller and the pixel array / readout path. It is the array's only source of the erase, expose, ramp and row-select signals.

## Interface
Parameters:
- ROWS, 2, number of pixel rows; one-hot row-select width.
- PIXEL_BITS, 8, ADC resolution; convert phase lasts 2^PIXEL_BITS cycles.
- ERASE_CYCLES, 5, erase phase length in cycles (≥1).
- ROW_READ_CYCLES, 5, cycles each row stays selected (≥2).
- EXPOSE_BITS, 8, width of the EXPOSE_TIME input.
- FRAME_CNT_BITS, 16, width of FRAME_COUNT.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset; asynchronous, active-high.
- START  in  1  request one frame; sampled only in IDLE.
- CONTINUOUS  in  1  when high at the last READ cycle, the next frame starts immediately.
- ABORT  in  1  synchronous abort to IDLE; has priority over everything except RESET.
- EXPOSE_TIME  in  EXPOSE_BITS  exposure length in cycles; latched at each frame start; 0 is treated as 1.
- BUSY  out  1  high in every state except IDLE.
- PIXEL_ERASE  out  1  high during ERASE.
- PIXEL_EXPOSE  out  1  high during EXPOSE.
- PIXEL_ANALOG_RAMP  out  1  ramp-generator enable, high during CONVERT (a level, not a gated clock).
- PIXEL_DIGITAL_RAMP  out  PIXEL_BITS  Gray-coded ramp value.
- SENSOR_ROW_SELECT  out  ROWS  one-hot row select during READ, otherwise all zero.
- NEW_ROW  out  1  one-cycle pulse in the first cycle of each selected row.
- FRAME_FINISHED  out  1  one-cycle pulse after a frame's final READ cycle.
- FRAME_COUNT  out  FRAME_CNT_BITS  completed-frame count; wraps modulo 2^FRAME_CNT_BITS.

## Operation
- States: IDLE → ERASE → EXPOSE → CONVERT → READ → (IDLE, or ERASE if CONTINUOUS).
- Single phase counter, wide enough for max(ERASE_CYCLES, 2^EXPOSE_BITS, 2^PIXEL_BITS, ROW_READ_CYCLES). It clears on every state entry.
- ERASE lasts ERASE_CYCLES cycles.
- EXPOSE lasts max(EXPOSE_TIME_latched, 1) cycles.
- CONVERT lasts 2^PIXEL_BITS cycles:
  - binary ramp counts 0 .. 2^PIXEL_BITS−1, one step per cycle;
  - PIXEL_DIGITAL_RAMP = bin ^ (bin>>1).
- READ lasts ROWS·ROW_READ_CYCLES cycles:
  - row r (r=0 first) is selected for ROW_READ_CYCLES consecutive cycles;
  - the row shift happens on the counter's terminal value;
  - exactly one bit is high in SENSOR_ROW_SELECT throughout READ.
- PIXEL_DIGITAL_RAMP clears to 0 on ERASE entry and holds its final value through READ and IDLE.
- EXPOSE_TIME is latched on the edge that leaves IDLE, and on the READ→ERASE edge in continuous mode. Changes mid-frame have no effect.
- START while BUSY is ignored (no queuing).
- FRAME_COUNT increments on the same edge that raises FRAME_FINISHED.
- ABORT in any non-IDLE state:
  - next cycle is IDLE with all array outputs low;
  - no FRAME_FINISHED, no count increment;
  - ramp cleared to 0.
- ABORT in IDLE is a no-op. ABORT together with START in IDLE: stay IDLE.

## Timing
- All outputs are registered, and all are 0 during and after RESET (FRAME_COUNT = 0, state IDLE).
- START is sampled high at edge 0. Phase cycles run as follows:
  - ERASE: 1 .. ERASE_CYCLES;
  - EXPOSE: next E cycles;
  - CONVERT: next 2^PIXEL_BITS cycles;
  - READ: next ROWS·ROW_READ_CYCLES cycles.
- FRAME_FINISHED is high in the cycle after the last READ cycle:
  - single-shot: state is IDLE and BUSY is low in that cycle;
  - continuous: state is ERASE and BUSY stays high.
- Output transitions occur on the same edge as the state change; there is no extra pipeline delay between state and outputs.
- NEW_ROW coincides with the first cycle in which the new SENSOR_ROW_SELECT bit is high.
- RESET mid-frame returns to IDLE asynchronously. FRAME_COUNT clears.

## Test plan
All scenarios use ROWS=4, PIXEL_BITS=8, ERASE_CYCLES=5, ROW_READ_CYCLES=5 (frame = 5+E+256+20).

- Single frame with EXPOSE_TIME=10, START at edge 0 → required response:
  - ERASE cycles 1–5, EXPOSE 6–15, CONVERT 16–271, READ 272–291;
  - FRAME_FINISHED at cycle 292 with BUSY low; FRAME_COUNT=1.
- Ramp check → PIXEL_DIGITAL_RAMP steps through Gray codes 0,1,3,2,…,0x80 during CONVERT. Exactly one bit changes per cycle. Value holds 0x80 through READ.
- Row readout → in READ, SENSOR_ROW_SELECT goes 0001,0010,0100,1000, 5 cycles each. Exactly 4 NEW_ROW pulses, at cycles 272, 277, 282, 287.
- Continuous mode with EXPOSE_TIME changed from 10 to 0 mid-frame:
  - frame 1 still exposes 10 cycles;
  - frame 2 ERASE starts at cycle 292 and exposes 1 cycle;
  - FRAME_COUNT=2 after 2 frames; BUSY never drops.
- ABORT at cycle 100 (in CONVERT) → required response:
  - IDLE at cycle 101, all outputs 0, ramp 0;
  - no FRAME_FINISHED, FRAME_COUNT unchanged;
  - START pulsed while BUSY before the abort is ignored.
- Asynchronous RESET at cycle 280 (in READ) → all outputs 0 immediately and FRAME_COUNT=0. A following START runs a full frame with nominal timing.

Source files
------------

// File: rtl/pixel_sequencer.sv
// Frame sequencer for the pixel array: erase, expose, convert (Gray ramp) and
// row-by-row readout, with programmable exposure, abort, free-run and frame count.
`timescale 1ns/1ps
module pixel_sequencer #(
   parameter int ROWS            = 2,
   parameter int PIXEL_BITS      = 8,
   parameter int ERASE_CYCLES    = 5,
   parameter int ROW_READ_CYCLES = 5,
   parameter int EXPOSE_BITS     = 8,
   parameter int FRAME_CNT_BITS  = 16
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      START,
   input  logic                      CONTINUOUS,
   input  logic                      ABORT,
   input  logic [EXPOSE_BITS-1:0]    EXPOSE_TIME,
   output logic                      BUSY,
   output logic                      PIXEL_ERASE,
   output logic                      PIXEL_EXPOSE,
   output logic                      PIXEL_ANALOG_RAMP,
   output logic [PIXEL_BITS-1:0]     PIXEL_DIGITAL_RAMP,
   output logic [ROWS-1:0]           SENSOR_ROW_SELECT,
   output logic                      NEW_ROW,
   output logic                      FRAME_FINISHED,
   output logic [FRAME_CNT_BITS-1:0] FRAME_COUNT
);

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int PHASE_MAX = max_int(max_int(ERASE_CYCLES, ROW_READ_CYCLES),
                                      max_int(2**EXPOSE_BITS, 2**PIXEL_BITS));
   localparam int CW = $clog2(PHASE_MAX);
   localparam logic [CW-1:0] ERASE_LAST   = CW'(ERASE_CYCLES - 1);
   localparam logic [CW-1:0] CONVERT_LAST = CW'(2**PIXEL_BITS - 1);
   localparam logic [CW-1:0] ROW_LAST     = CW'(ROW_READ_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ERASE   = 3'd1,
      S_EXPOSE  = 3'd2,
      S_CONVERT = 3'd3,
      S_READ    = 3'd4
   } state_t;

   state_t                    state_reg, state_next;
   logic [CW-1:0]             cnt_reg, cnt_next;
   logic [EXPOSE_BITS-1:0]    exp_reg, exp_next;
   logic                      busy_reg, busy_next;
   logic                      erase_reg, erase_next;
   logic                      expose_reg, expose_next;
   logic                      ramp_en_reg, ramp_en_next;
   logic [PIXEL_BITS-1:0]     ramp_reg, ramp_next;
   logic [ROWS-1:0]           row_sel_reg, row_sel_next;
   logic                      new_row_reg, new_row_next;
   logic                      finished_reg, finished_next;
   logic [FRAME_CNT_BITS-1:0] count_reg, count_next;

   logic                      abort_hit;
   logic                      row_last;
   logic                      frame_last;
   logic [CW-1:0]             expose_last;
   logic [PIXEL_BITS-1:0]     ramp_bin;
   logic [PIXEL_BITS-1:0]     ramp_gray;

   assign abort_hit   = ABORT && (state_reg != S_IDLE);
   assign row_last    = (cnt_reg == ROW_LAST);
   assign frame_last  = (state_reg == S_READ) && row_last && row_sel_reg[ROWS-1];
   // A latched exposure of 0 behaves like 1: the phase ends at count 0 either way.
   assign expose_last = (exp_reg == '0) ? '0 : CW'(exp_reg) - CW'(1);

   // Gray code of the ramp value the counter will hold next cycle.
   assign ramp_bin = cnt_next[PIXEL_BITS-1:0];
   generate
      for (genvar gi = 0; gi < PIXEL_BITS - 1; gi++) begin : g_gray
         assign ramp_gray[gi] = ramp_bin[gi] ^ ramp_bin[gi+1];
      end
   endgenerate
   assign ramp_gray[PIXEL_BITS-1] = ramp_bin[PIXEL_BITS-1];

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_reg    <= S_IDLE;
         cnt_reg      <= '0;
         exp_reg      <= '0;
         busy_reg     <= 1'b0;
         erase_reg    <= 1'b0;
         expose_reg   <= 1'b0;
         ramp_en_reg  <= 1'b0;
         ramp_reg     <= '0;
         row_sel_reg  <= '0;
         new_row_reg  <= 1'b0;
         finished_reg <= 1'b0;
         count_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         exp_reg      <= exp_next;
         busy_reg     <= busy_next;
         erase_reg    <= erase_next;
         expose_reg   <= expose_next;
         ramp_en_reg  <= ramp_en_next;
         ramp_reg     <= ramp_next;
         row_sel_reg  <= row_sel_next;
         new_row_reg  <= new_row_next;
         finished_reg <= finished_next;
         count_reg    <= count_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:    if (START && !ABORT)             state_next = S_ERASE;
         S_ERASE:   if (cnt_reg == ERASE_LAST)       state_next = S_EXPOSE;
         S_EXPOSE:  if (cnt_reg == expose_last)      state_next = S_CONVERT;
         S_CONVERT: if (cnt_reg == CONVERT_LAST)     state_next = S_READ;
         S_READ:    if (frame_last)                  state_next = CONTINUOUS ? S_ERASE : S_IDLE;
         default:                                    state_next = S_IDLE;
      endcase
      if (abort_hit) state_next = S_IDLE;

      // One counter serves every phase; in READ it wraps once per row.
      if (state_next != state_reg || state_next == S_IDLE)
         cnt_next = '0;
      else if (state_reg == S_READ && row_last)
         cnt_next = '0;
      else
         cnt_next = cnt_reg + CW'(1);
   end

   always_comb begin
      busy_next     = (state_next != S_IDLE);
      erase_next    = (state_next == S_ERASE);
      expose_next   = (state_next == S_EXPOSE);
      ramp_en_next  = (state_next == S_CONVERT);

      ramp_next = ramp_reg;
      if (abort_hit || state_next == S_ERASE)
         ramp_next = '0;
      else if (state_next == S_CONVERT)
         ramp_next = ramp_gray;

      row_sel_next = '0;
      if (state_next == S_READ) begin
         if (state_reg != S_READ)
            row_sel_next = ROWS'(1);
         else if (row_last)
            row_sel_next = row_sel_reg << 1;
         else
            row_sel_next = row_sel_reg;
      end
      new_row_next  = (state_next == S_READ) && ((state_reg != S_READ) || row_last);

      finished_next = frame_last && !ABORT;
      count_next    = count_reg + FRAME_CNT_BITS'(finished_next);

      exp_next = exp_reg;
      if (state_next == S_ERASE && state_reg != S_ERASE)
         exp_next = EXPOSE_TIME;
   end

   assign BUSY               = busy_reg;
   assign PIXEL_ERASE        = erase_reg;
   assign PIXEL_EXPOSE       = expose_reg;
   assign PIXEL_ANALOG_RAMP  = ramp_en_reg;
   assign PIXEL_DIGITAL_RAMP = ramp_reg;
   assign SENSOR_ROW_SELECT  = row_sel_reg;
   assign NEW_ROW            = new_row_reg;
   assign FRAME_FINISHED     = finished_reg;
   assign FRAME_COUNT        = count_reg;

endmodule
